// File: rtl/ifu_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// ifu_fetch_ctrl
// Instruction-fetch controller. Owns the fetch PC, drives a combinational
// instruction ROM and buffers {pc, instr} pairs in a small prefetch queue.
// Decode drains the queue through a valid/ready handshake.
//
// Handshake: a transfer happens on a rising edge where out_valid and
// out_ready are both high and redirect_valid is low. out_valid never
// depends on out_ready. The head entry (out_pc/out_instr) only changes
// on a transfer, on a push into an empty queue, on a flush or on reset.
//
// Ports:
//   clk            in   system clock, all state on rising edge
//   rst_n          in   synchronous active-low reset
//   im_pc          out  ROM byte address (always the fetch PC)
//   im_instr       in   ROM data for im_pc, same cycle
//   redirect_valid in   load redirect_pc as fetch PC, flush queue
//   redirect_pc    in   redirect target byte address
//   halt           in   suspend new fetches, queue keeps draining
//   out_valid      out  head entry valid
//   out_ready      in   decode accepts head
//   out_pc         out  PC of head entry (0 when queue empty)
//   out_instr      out  instruction of head entry (0 when queue empty)
//   fetch_fault    out  fault reached and all older instructions drained
//   fault_pc       out  offending fetch PC
//   instr_count    out  number of completed handshakes
//   dbg_state      out  FSM state (0 RUN, 1 HALTED, 2 FAULT)
// ---------------------------------------------------------------------------
module ifu_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          IM_WORDS = 4096,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] im_pc,
    input  logic [31:0] im_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        fetch_fault,
    output logic [31:0] fault_pc,
    output logic [31:0] instr_count,
    output logic [1:0]  dbg_state
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [31:0]      IM_WORDS_C = 32'(IM_WORDS);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_HALTED = 2'd1;
    localparam logic [1:0] ST_FAULT  = 2'd2;

    logic [1:0]       r_state;
    logic [31:0]      r_fetch_pc;
    logic [31:0]      r_fault_pc;
    logic [31:0]      r_instr_count;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_q_pc    [DEPTH];
    logic [31:0]      r_q_instr [DEPTH];

    logic w_bad_pc;
    logic w_empty;
    logic w_pop;
    logic w_push;

    // Misaligned or beyond the last ROM word.
    assign w_bad_pc = (r_fetch_pc[1:0] != 2'b00) || ((r_fetch_pc >> 2) >= IM_WORDS_C);
    assign w_empty  = (r_count == '0);
    assign w_pop    = !w_empty && out_ready && !redirect_valid;
    // A full queue may still accept a push when the head leaves this cycle.
    assign w_push   = (r_state == ST_RUN) && !halt && !redirect_valid && !w_bad_pc &&
                      ((r_count < DEPTH_C) || w_pop);

    assign im_pc       = r_fetch_pc;
    assign out_valid   = !w_empty;
    assign out_pc      = w_empty ? 32'h0 : r_q_pc[r_rd_ptr];
    assign out_instr   = w_empty ? 32'h0 : r_q_instr[r_rd_ptr];
    // Reported only once every older instruction has left the queue.
    assign fetch_fault = (r_state == ST_FAULT) && w_empty;
    assign fault_pc    = r_fault_pc;
    assign instr_count = r_instr_count;
    assign dbg_state   = r_state;

    // Control state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_fetch_pc    <= RESET_PC;
            r_fault_pc    <= 32'h0;
            r_instr_count <= 32'h0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
        end else if (redirect_valid) begin
            r_state    <= ST_RUN;
            r_fetch_pc <= redirect_pc;
            r_fault_pc <= 32'h0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_pop) begin
                r_rd_ptr      <= r_rd_ptr + PTR_W'(1);
                r_instr_count <= r_instr_count + 32'd1;
            end
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            // FAULT is left only through redirect or reset.
            if (r_state != ST_FAULT) begin
                if (halt) begin
                    r_state <= ST_HALTED;
                end else if (r_state == ST_RUN && w_bad_pc) begin
                    r_state    <= ST_FAULT;
                    r_fault_pc <= r_fetch_pc;
                end else begin
                    r_state <= ST_RUN;
                end
            end
        end
    end

    // Queue storage; contents are masked by the count, so no reset needed.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_q_pc[r_wr_ptr]    <= r_fetch_pc;
            r_q_instr[r_wr_ptr] <= im_instr;
        end
    end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
module tb_ifu_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] im_pc;
    logic [31:0] im_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        fetch_fault;
    logic [31:0] fault_pc;
    logic [31:0] instr_count;
    logic [1:0]  dbg_state;

    int tests_run;
    int tests_failed;

    // ROM word i holds 32'hDEAD_0000 | i.
    logic [31:0] rom [0:4095];
    assign im_instr = rom[im_pc[13:2]];

    ifu_fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .im_pc          (im_pc),
        .im_instr       (im_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .fetch_fault    (fetch_fault),
        .fault_pc       (fault_pc),
        .instr_count    (instr_count),
        .dbg_state      (dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; halt = 1'b0; out_ready = 1'b0;
        tick(); tick();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        tests_run++; if (out_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
        tests_run++; if (out_instr !== 32'h0) begin tests_failed++; $display("FAIL reset_out_instr: got %h want 0", out_instr); end
        tests_run++; if (fetch_fault !== 1'b0) begin tests_failed++; $display("FAIL reset_fault: got %b want 0", fetch_fault); end
        tests_run++; if (fault_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_fault_pc: got %h want 0", fault_pc); end
        tests_run++; if (instr_count !== 32'h0) begin tests_failed++; $display("FAIL reset_count: got %h want 0", instr_count); end
        tests_run++; if (im_pc !== 32'h3000) begin tests_failed++; $display("FAIL reset_im_pc: got %h want 3000", im_pc); end
    endtask

    task automatic test_run();
        logic [31:0] exp_instr [4];
        exp_instr[0] = 32'hDEAD_0C00; exp_instr[1] = 32'hDEAD_0C01;
        exp_instr[2] = 32'hDEAD_0C02; exp_instr[3] = 32'hDEAD_0C03;
        out_ready = 1'b1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL run_valid%0d: got %b want 1", k, out_valid); end
            tests_run++; if (out_pc !== 32'h3000 + 32'(4 * k)) begin tests_failed++; $display("FAIL run_pc%0d: got %h want %h", k, out_pc, 32'h3000 + 32'(4 * k)); end
            tests_run++; if (out_instr !== exp_instr[k]) begin tests_failed++; $display("FAIL run_instr%0d: got %h want %h", k, out_instr, exp_instr[k]); end
        end
        tick();
        tests_run++; if (instr_count !== 32'd4) begin tests_failed++; $display("FAIL run_count: got %0d want 4", instr_count); end
    endtask

    task automatic test_backpressure();
        rst_n = 1'b0; out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        tests_run++; if (out_pc !== 32'h3000) begin tests_failed++; $display("FAIL bp_hold_pc: got %h want 3000", out_pc); end
        tests_run++; if (im_pc !== 32'h3008) begin tests_failed++; $display("FAIL bp_im_pc: got %h want 3008", im_pc); end
        tests_run++; if (instr_count !== 32'd0) begin tests_failed++; $display("FAIL bp_count0: got %0d want 0", instr_count); end
        out_ready = 1'b1;
        tick();
        tests_run++; if (out_pc !== 32'h3004) begin tests_failed++; $display("FAIL bp_pc1: got %h want 3004", out_pc); end
        tick();
        tests_run++; if (out_pc !== 32'h3008) begin tests_failed++; $display("FAIL bp_pc2: got %h want 3008", out_pc); end
        tests_run++; if (out_instr !== 32'hDEAD_0C02) begin tests_failed++; $display("FAIL bp_instr2: got %h want DEAD0C02", out_instr); end
        tests_run++; if (instr_count !== 32'd2) begin tests_failed++; $display("FAIL bp_count2: got %0d want 2", instr_count); end
        tests_run++; if (im_pc !== 32'h3010) begin tests_failed++; $display("FAIL bp_im_pc2: got %h want 3010", im_pc); end
    endtask

    // Queue is full ([3008,300C]) with out_ready high on entry.
    task automatic test_redirect();
        redirect_valid = 1'b1; redirect_pc = 32'h3100;
        tick();
        redirect_valid = 1'b0;
        tests_run++; if (instr_count !== 32'd2) begin tests_failed++; $display("FAIL redir_no_pop: got %0d want 2", instr_count); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_flush: got %b want 0", out_valid); end
        tests_run++; if (im_pc !== 32'h3100) begin tests_failed++; $display("FAIL redir_im_pc: got %h want 3100", im_pc); end
        tick();
        tests_run++; if (out_pc !== 32'h3100) begin tests_failed++; $display("FAIL redir_pc: got %h want 3100", out_pc); end
        tests_run++; if (out_instr !== 32'hDEAD_0C40) begin tests_failed++; $display("FAIL redir_instr: got %h want DEAD0C40", out_instr); end
    endtask

    task automatic test_halt();
        halt = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL halt_drain: got %b want 0", out_valid); end
        tests_run++; if (im_pc !== 32'h3104) begin tests_failed++; $display("FAIL halt_im_pc: got %h want 3104", im_pc); end
        tests_run++; if (dbg_state !== 2'd1) begin tests_failed++; $display("FAIL halt_state: got %0d want 1", dbg_state); end
        tests_run++; if (instr_count !== 32'd3) begin tests_failed++; $display("FAIL halt_count: got %0d want 3", instr_count); end
        halt = 1'b0;
        for (int k = 0; k < 4 && !out_valid; k++) tick();
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++; $display("FAIL halt_resume_timeout: got out_valid %b want 1", out_valid);
        end else if (out_pc !== 32'h3104 || out_instr !== 32'hDEAD_0C41) begin
            tests_failed++; $display("FAIL halt_resume: got %h/%h want 3104/DEAD0C41", out_pc, out_instr);
        end
    endtask

    task automatic test_fault();
        redirect_valid = 1'b1; redirect_pc = 32'h3FFC; out_ready = 1'b0;
        tick();
        redirect_valid = 1'b0;
        tick();
        tests_run++; if (out_pc !== 32'h3FFC || out_instr !== 32'hDEAD_0FFF) begin tests_failed++; $display("FAIL flt_last_word: got %h/%h want 3FFC/DEAD0FFF", out_pc, out_instr); end
        tick();
        // Fault is pending but an older instruction is still queued.
        tests_run++; if (fetch_fault !== 1'b0) begin tests_failed++; $display("FAIL flt_order: got %b want 0", fetch_fault); end
        tests_run++; if (dbg_state !== 2'd2) begin tests_failed++; $display("FAIL flt_state: got %0d want 2", dbg_state); end
        out_ready = 1'b1;
        tick();
        tests_run++; if (fetch_fault !== 1'b1) begin tests_failed++; $display("FAIL flt_range: got %b want 1", fetch_fault); end
        tests_run++; if (fault_pc !== 32'h4000) begin tests_failed++; $display("FAIL flt_range_pc: got %h want 4000", fault_pc); end
        tests_run++; if (im_pc !== 32'h4000) begin tests_failed++; $display("FAIL flt_hold_pc: got %h want 4000", im_pc); end
        halt = 1'b1;
        tick(); tick();
        halt = 1'b0;
        tests_run++; if (fetch_fault !== 1'b1) begin tests_failed++; $display("FAIL flt_sticky: got %b want 1", fetch_fault); end
        redirect_valid = 1'b1; redirect_pc = 32'h3002;
        tick();
        redirect_valid = 1'b0;
        tests_run++; if (fetch_fault !== 1'b0 || fault_pc !== 32'h0) begin tests_failed++; $display("FAIL flt_redir_clear: got %b/%h want 0/0", fetch_fault, fault_pc); end
        tick();
        tests_run++; if (fetch_fault !== 1'b1 || fault_pc !== 32'h3002) begin tests_failed++; $display("FAIL flt_misalign: got %b/%h want 1/3002", fetch_fault, fault_pc); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flt_misalign_valid: got %b want 0", out_valid); end
        redirect_valid = 1'b1; redirect_pc = 32'h3000;
        tick();
        redirect_valid = 1'b0;
        tests_run++; if (fetch_fault !== 1'b0 || fault_pc !== 32'h0) begin tests_failed++; $display("FAIL flt_clear: got %b/%h want 0/0", fetch_fault, fault_pc); end
        tick();
        tests_run++; if (out_pc !== 32'h3000 || out_instr !== 32'hDEAD_0C00) begin tests_failed++; $display("FAIL flt_restart: got %h/%h want 3000/DEAD0C00", out_pc, out_instr); end
    endtask

    task automatic test_reset_mid();
        redirect_valid = 1'b1; redirect_pc = 32'h3FF8; out_ready = 1'b0;
        tick();
        redirect_valid = 1'b0;
        tick(); tick(); tick();
        tests_run++; if (dbg_state !== 2'd2 || out_valid !== 1'b1 || out_pc !== 32'h3FF8) begin tests_failed++; $display("FAIL mid_setup: got st %0d v %b pc %h want 2/1/3FF8", dbg_state, out_valid, out_pc); end
        rst_n = 1'b0; out_ready = 1'b1; halt = 1'b1;
        tick();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_valid: got %b want 0", out_valid); end
        tests_run++; if (fetch_fault !== 1'b0) begin tests_failed++; $display("FAIL mid_fault: got %b want 0", fetch_fault); end
        tests_run++; if (instr_count !== 32'h0) begin tests_failed++; $display("FAIL mid_count: got %0d want 0", instr_count); end
        tests_run++; if (im_pc !== 32'h3000) begin tests_failed++; $display("FAIL mid_im_pc: got %h want 3000", im_pc); end
        tests_run++; if (dbg_state !== 2'd0) begin tests_failed++; $display("FAIL mid_state: got %0d want 0", dbg_state); end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        for (int i = 0; i < 4096; i++) rom[i] = 32'hDEAD_0000 | 32'(i);
        test_reset();
        test_run();
        test_backpressure();
        test_redirect();
        test_halt();
        test_fault();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
